// File: rtl/mul32_rr_scheduler.sv
// Round-robin scheduler that shares one combinational 32x32 unsigned multiplier
// among NREQ requesters, with registered operand and product stages.

module mul32x32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [63:0] p
);
    assign p = 64'(a) * 64'(b);
endmodule

module mul32_rr_scheduler #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*32-1:0]   req_a,
    input  logic [NREQ*32-1:0]   req_b,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [IDW-1:0]       rsp_id,
    output logic [63:0]          rsp_p,
    output logic                 busy,
    output logic [31:0]          op_count
);

    typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;

    state_t         state;
    logic [IDW-1:0] ptr;
    logic [IDW-1:0] id_r;
    logic [31:0]    a_r;
    logic [31:0]    b_r;
    logic [63:0]    mul_p;

    logic [IDW-1:0] grant;
    logic           grant_found;
    logic [31:0]    a_sel;
    logic [31:0]    b_sel;

    // Search starts just after the last winner, so the most recent grantee is checked last.
    always_comb begin
        logic [IDW:0] cand;
        grant       = '0;
        grant_found = 1'b0;
        a_sel       = '0;
        b_sel       = '0;
        cand        = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = {1'b0, ptr} + (IDW+1)'(k);
            if (cand >= (IDW+1)'(NREQ)) begin
                cand = cand - (IDW+1)'(NREQ);
            end
            if (!grant_found && req_valid[cand[IDW-1:0]]) begin
                grant       = cand[IDW-1:0];
                grant_found = 1'b1;
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (grant == IDW'(i)) begin
                a_sel = req_a[32*i +: 32];
                b_sel = req_b[32*i +: 32];
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (state == IDLE && rst_n && grant_found) begin
            req_ready[grant] = 1'b1;
        end
    end

    mul32x32 u_mul (
        .a (a_r),
        .b (b_r),
        .p (mul_p)
    );

    // Reset discards any operation in flight; the pointer starts at NREQ-1 so requester 0 wins first.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= IDW'(NREQ - 1);
            id_r      <= '0;
            a_r       <= '0;
            b_r       <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_p     <= '0;
            busy      <= 1'b0;
            op_count  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_found) begin
                        a_r   <= a_sel;
                        b_r   <= b_sel;
                        id_r  <= grant;
                        ptr   <= grant;
                        busy  <= 1'b1;
                        state <= CALC;
                    end
                end
                CALC: begin
                    rsp_p     <= mul_p;
                    rsp_id    <= id_r;
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        op_count  <= op_count + 32'd1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/mul32_rr_scheduler.md
Name: mul32_rr_scheduler

Overview:
- Shares one combinational mul32x32 instance among NREQ requesters.
- Each requester issues an unsigned 32x32 multiply over a valid/ready handshake. A round-robin arbiter grants one requester at a time.
- The operand stage and the product stage are registered around the multiplier. One response channel returns the 64-bit product tagged with the requester index.
- Sits between the integer-execute clients (ALU slots and the DSP helper) and the shared multiplier.

Parameters:
- NREQ, 4, number of requesters; legal range 2..16.
- IDW, $clog2(NREQ), width of the requester index/tag.

Ports:
- clk  input  1  single clock; all logic is rising-edge.
- rst_n  input  1  synchronous, active-low reset.
- req_valid  input  NREQ  per-requester request valid.
- req_ready  output  NREQ  per-requester accept; at most one bit is high per cycle.
- req_a  input  NREQ*32  operand A; requester i uses bits [32*i+31:32*i].
- req_b  input  NREQ*32  operand B; same packing as req_a.
- rsp_valid  output  1  product available.
- rsp_ready  input  1  consumer accepts the product.
- rsp_id  output  IDW  index of the requester that owns rsp_p.
- rsp_p  output  64  unsigned product a*b.
- busy  output  1  high whenever the FSM is not in IDLE.
- op_count  output  32  number of completed response handshakes.

Behaviour:
- Reset (rst_n low at a clk edge, synchronous):
  - FSM goes to IDLE.
  - rsp_valid=0, rsp_id=0, rsp_p=0, busy=0, op_count=0, req_ready=0.
  - The priority pointer is set to NREQ-1, so requester 0 wins first.
  - Any in-flight operation is discarded; no response is ever produced for it.
- FSM states: IDLE, CALC, RESP.
- IDLE:
  - Round-robin grant is combinational. Search starts at (ptr+1) mod NREQ and the first set req_valid bit wins.
  - req_ready[g] is 1 only for the winner g.
  - On handshake (req_valid[g] and req_ready[g]) the block registers a_r, b_r and id_r=g, sets ptr=g, and moves to CALC.
  - If no requests are pending, it stays in IDLE with ptr unchanged.
- CALC:
  - a_r and b_r drive the mul32x32 instance.
  - At the end of the cycle, p_r is loaded with the product, rsp_id is loaded with id_r, rsp_valid is set to 1, and the FSM moves to RESP.
- RESP:
  - rsp_valid, rsp_id and rsp_p are held stable until rsp_ready=1.
  - On handshake: rsp_valid=0 and op_count increments by 1, wrapping from 0xFFFF_FFFF to 0. The FSM then returns to IDLE.
  - While the FSM is in CALC or RESP, req_ready is all zeros.
- Timing:
  - A request accepted at cycle T gives rsp_valid=1 at cycle T+2.
  - The next grant comes no earlier than the cycle after the response handshake.
  - Peak throughput is 1 operation per 3 cycles.
- Requester contract: a requester holds req_valid and its operands stable until accepted. The block does not check this.
- Arithmetic: full unsigned 64-bit product, with no truncation and no signed mode.
  - 0xFFFF_FFFF*0xFFFF_FFFF = 0xFFFF_FFFE_0000_0001.
- Boundary conditions:
  - A requester that drops req_valid before it is granted loses its slot; nothing is latched.
  - rsp_ready held high permanently gives a steady 3-cycle cadence.
  - rsp_ready held low stalls the whole block indefinitely with no loss of data.
  - When all NREQ requesters are valid continuously, grants rotate 0,1,…,NREQ-1,0.
  - A requester that re-asserts req_valid immediately after being granted still waits behind the other valid requesters.
  - ptr wrap: when ptr=NREQ-1, the search starts at index 0.
  - Reset asserted during RESP clears rsp_valid at the next edge, even if rsp_ready=0.

Test Plan:
- Reset and idle check:
  - Stimulus: rst_n=0 for 2 cycles, then release with no requests.
  - Required: rsp_valid=0, busy=0, req_ready=0, op_count=0.
- Single request, latency:
  - Stimulus: req_valid[2]=1, a=0x1234_5678, b=0x9ABC_DEF0, accepted at T; rsp_ready=1.
  - Required: rsp_valid rises at T+2 with rsp_id=2 and rsp_p=0x0B00_EA4E_242D_2080; op_count=1 after the handshake.
- Corner operands:
  - Stimulus: (0xFFFF_FFFF,0xFFFF_FFFF), (0x8000_0000,2), (0,0xFFFF_FFFF).
  - Required: products 0xFFFF_FFFE_0000_0001, 0x1_0000_0000 and 0 respectively.
- Round-robin fairness:
  - Stimulus: all 4 req_valid high for 8 operations, each requester with distinct operands.
  - Required: grant/rsp_id order is 0,1,2,3,0,1,2,3, and every product is correct.
- Backpressure:
  - Stimulus: rsp_ready=0 for 10 cycles after rsp_valid rises.
  - Required: rsp_valid, rsp_id and rsp_p stay constant; req_ready=0 throughout; op_count unchanged until rsp_ready=1.
- Reset mid-operation and random soak:
  - Stimulus: assert rst_n=0 while in RESP, then run 100000 random operations with random req_valid/rsp_ready and compare each against a*b.
  - Required: after the reset there is no stale response and op_count=0; the soak has zero mismatches, and op_count equals the number of completed handshakes.
